// File: rtl/led_bargraph_timer.sv
// rtl/led_bargraph_timer.sv - prescaled tick counter driving an LED bar/dot indicator (optional dot decode: LED_BARGRAPH_DOT_MODE_EN)
module led_bargraph_timer #(
    parameter int DIV           = 50000000,
    parameter int N_LED         = 6,
    parameter int STEPS_PER_LED = 10,
    parameter int TOTAL         = N_LED * STEPS_PER_LED,
    parameter int SW            = $clog2(TOTAL + 1)
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    output logic [N_LED-1:0] led,
    output logic             tick,
    output logic             wrap,
    output logic             sq_out,
    output logic [SW-1:0]    step
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
    localparam logic [SW-1:0] S_MAX = SW'(TOTAL);

    logic [CW-1:0]    cnt;
    logic [SW-1:0]    s;
    logic [SW-1:0]    s_next;
    logic [N_LED-1:0] led_next;

    // Bar decode: every LED below the current level is lit.
    function automatic logic [N_LED-1:0] bar_decode(input logic [SW-1:0] sv);
        int lvl;
        bar_decode = '0;
        lvl = int'(sv) / STEPS_PER_LED;
        for (int i = 0; i < N_LED; i++) begin
            bar_decode[i] = (i < lvl);
        end
    endfunction

`ifdef LED_BARGRAPH_DOT_MODE_EN
    // Dot decode: only the topmost LED of the level is lit; level 0 lights nothing.
    function automatic logic [N_LED-1:0] dot_decode(input logic [SW-1:0] sv);
        int lvl;
        dot_decode = '0;
        lvl = int'(sv) / STEPS_PER_LED;
        for (int i = 0; i < N_LED; i++) begin
            dot_decode[i] = (i == lvl - 1);
        end
    endfunction

    assign led_next = mode ? dot_decode(s_next) : bar_decode(s_next);
`else
    // Without dot support the mode pin is kept only so instantiations stay unchanged.
    logic unused_mode;
    assign unused_mode = mode;
    assign led_next    = bar_decode(s_next);
`endif

    // Tick is masked by clear so a clear can never advance the step or raise wrap.
    assign tick = (cnt == CNT_MAX) & en & ~clr;
    assign step = s;

    // Next step value; clear wins, otherwise advance on tick and wrap after TOTAL.
    always_comb begin
        s_next = s;
        if (clr) begin
            s_next = '0;
        end else if (tick) begin
            s_next = (s == S_MAX) ? '0 : s + 1'b1;
        end
    end

    // Prescaler, step, LED, wrap and heartbeat registers.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            s      <= '0;
            led    <= '0;
            wrap   <= 1'b0;
            sq_out <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end
            s    <= s_next;
            led  <= led_next;
            wrap <= tick & (s == S_MAX);
            // Heartbeat follows the prescaler one cycle late and freezes with it.
            if (en) begin
                sq_out <= (cnt >= CNT_HALF);
            end
        end
    end

endmodule

// File: tb/tb_led_bargraph_timer.sv
// tb/tb_led_bargraph_timer.sv - scoreboard bench for led_bargraph_timer (DIV=4, N_LED=3, STEPS_PER_LED=2)
module tb_led_bargraph_timer;

    localparam int DIV = 4;
    localparam int N_LED = 3;
    localparam int SPL = 2;
    localparam int SW = 3;

`ifdef LED_BARGRAPH_DOT_MODE_EN
    localparam logic [31:0] DOT_L1 = 32'h1;
    localparam logic [31:0] DOT_L2 = 32'h2;
    localparam logic [31:0] DOT_L3 = 32'h4;
`else
    localparam logic [31:0] DOT_L1 = 32'h1;
    localparam logic [31:0] DOT_L2 = 32'h3;
    localparam logic [31:0] DOT_L3 = 32'h7;
`endif

    logic             clkin = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic             mode;
    logic [N_LED-1:0] led;
    logic             tick;
    logic             wrap;
    logic             sq_out;
    logic [SW-1:0]    step;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n;

    led_bargraph_timer #(
        .DIV(DIV),
        .N_LED(N_LED),
        .STEPS_PER_LED(SPL)
    ) dut (
        .clkin (clkin),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .mode  (mode),
        .led   (led),
        .tick  (tick),
        .wrap  (wrap),
        .sq_out(sq_out),
        .step  (step)
    );

    always #5 clkin = ~clkin;

    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        while (tick !== 1'b1 && cycles < 50) begin
            cyc();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0;

        // Reset held three cycles: everything quiet.
        expect_v("rst_led", 32'h0); expect_v("rst_tick", 32'h0); expect_v("rst_wrap", 32'h0);
        expect_v("rst_sq", 32'h0); expect_v("rst_step", 32'h0);
        repeat (3) cyc();
        check_v(32'(led)); check_v(32'(tick)); check_v(32'(wrap));
        check_v(32'(sq_out)); check_v(32'(step));

        // Full bar sweep from reset release, checked every cycle.
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            expect_v("tick", (k % 4 == 3) ? 32'h1 : 32'h0);
            expect_v("sq", ((k - 1) % 4 >= 2) ? 32'h1 : 32'h0);
            expect_v("step", (k >= 28) ? 32'h0 : 32'(k / 4));
            expect_v("wrap", (k == 28) ? 32'h1 : 32'h0);
            if (k == 8)  expect_v("bar_led2", 32'h1);
            if (k == 16) expect_v("bar_led4", 32'h3);
            if (k == 24) expect_v("bar_led6", 32'h7);
            if (k == 28) expect_v("bar_led_wrap", 32'h0);
            cyc();
            check_v(32'(tick)); check_v(32'(sq_out)); check_v(32'(step)); check_v(32'(wrap));
            if (k == 8 || k == 16 || k == 24 || k == 28) check_v(32'(led));
        end

        // Advance to step 4, then assert reset between edges.
        expect_v("tick_gap_first", 32'd2);
        wait_tick(n); check_v(32'(n));
        cyc();
        for (int t = 0; t < 3; t++) begin
            expect_v("tick_gap", 32'd3);
            wait_tick(n); check_v(32'(n));
            cyc();
        end
        expect_v("pre_rst_step", 32'd4); expect_v("pre_rst_led", 32'h3);
        check_v(32'(step)); check_v(32'(led));
        expect_v("async_rst_step", 32'h0); expect_v("async_rst_led", 32'h0);
        rst = 1'b1;
        #1;
        check_v(32'(step)); check_v(32'(led));
        repeat (2) cyc();

        // Dot-mode sweep with a pause while tick is pending at step 3.
        rst = 1'b0; mode = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            expect_v("dot_gap", 32'd3);
            wait_tick(n); check_v(32'(n));
            expect_v("dot_step", 32'(t));
            expect_v("dot_led", (t == 1) ? 32'h0 : DOT_L1);
            cyc();
            check_v(32'(step)); check_v(32'(led));
        end
        expect_v("pre_pause_gap", 32'd3);
        wait_tick(n); check_v(32'(n));
        expect_v("pause_tick_mask", 32'h0);
        en = 1'b0;
        #1;
        check_v(32'(tick));
        for (int t = 0; t < 10; t++) begin
            expect_v("pause_step", 32'd3); expect_v("pause_led", DOT_L1);
            expect_v("pause_sq", 32'h1); expect_v("pause_tick", 32'h0);
            cyc();
            check_v(32'(step)); check_v(32'(led)); check_v(32'(sq_out)); check_v(32'(tick));
        end
        expect_v("resume_tick", 32'h1);
        en = 1'b1;
        #1;
        check_v(32'(tick));
        expect_v("dot_step4", 32'd4); expect_v("dot_led4", DOT_L2);
        cyc();
        check_v(32'(step)); check_v(32'(led));
        for (int t = 5; t <= 6; t++) begin
            expect_v("dot_gap_late", 32'd3);
            wait_tick(n); check_v(32'(n));
            expect_v("dot_step_late", 32'(t));
            expect_v("dot_led_late", (t == 6) ? DOT_L3 : DOT_L2);
            cyc();
            check_v(32'(step)); check_v(32'(led));
        end

        // Mode change while disabled re-decodes the held step.
        en = 1'b0; mode = 1'b0;
        expect_v("mode_hold_led", 32'h7); expect_v("mode_hold_step", 32'd6);
        cyc();
        check_v(32'(led)); check_v(32'(step));

        // Clear coincident with the wrapping tick at step 6.
        en = 1'b1; mode = 1'b1;
        expect_v("pre_clr_gap", 32'd3);
        wait_tick(n); check_v(32'(n));
        expect_v("clr_tick_mask", 32'h0);
        clr = 1'b1;
        #1;
        check_v(32'(tick));
        expect_v("clr_step", 32'h0); expect_v("clr_led", 32'h0); expect_v("clr_wrap", 32'h0);
        cyc();
        check_v(32'(step)); check_v(32'(led)); check_v(32'(wrap));
        clr = 1'b0;
        expect_v("clr_wrap_after", 32'h0);
        cyc();
        check_v(32'(wrap));
        expect_v("post_clr_gap", 32'd2);
        wait_tick(n); check_v(32'(n));
        expect_v("post_clr_step", 32'h0);
        check_v(32'(step));

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_bargraph_timer.md
# led_bargraph_timer

Parametrised prescaler plus bar-graph step indicator for the board LED bank. Divides `clkin` down to a programmable tick, counts ticks, and drives `N_LED` LEDs as a filling bar or single moving dot, wrapping after a full sweep. Everything runs in the `clkin` domain with no derived clocks. Also exports a square-wave heartbeat, wrap pulse and raw step count for other blocks.

## Interface
- `DIV`, default 50000000: `clkin` cycles per tick; must be at least 2.
- `N_LED`, default 6: number of LED outputs; must be at least 1.
- `STEPS_PER_LED`, default 10: ticks per bar level; must be at least 1.
- `TOTAL`, derived: `N_LED*STEPS_PER_LED`. `SW`, derived: `$clog2(TOTAL+1)`.
- `clkin  in  1`: clock.
- `rst  in  1`: reset; asynchronous, active-high.
- `en  in  1`: count enable; when low, prescaler and step hold.
- `clr  in  1`: synchronous clear of prescaler and step.
- `mode  in  1`: 0 = bar, 1 = dot (effective only with the macro; see Configuration).
- `led  out  N_LED`: LED drive, registered.
- `tick  out  1`: one-cycle prescaler pulse.
- `wrap  out  1`: one-cycle pulse on sweep wrap, registered.
- `sq_out  out  1`: heartbeat square wave, registered.
- `step  out  SW`: current step count, 0..TOTAL.

## Operation
- Prescaler `cnt` has width `$clog2(DIV)` and range 0..DIV-1.
  - If `en`=1, it increments each cycle and wraps DIV-1 → 0.
- `tick` = (`cnt`==DIV-1) & `en` & ~`clr`, decoded from registers.
- Step counter `s` has range 0..TOTAL.
  - On a cycle with `tick`=1: if `s`==TOTAL then `s`←0, else `s`←`s`+1.
  - `step` = `s`.
- Level L = `s` / STEPS_PER_LED, range 0..N_LED (integer divide).
- Bar mode: `led[i]`=1 iff i < L.
  - L=0 gives all LEDs off; `s`=TOTAL gives all on.
- Dot mode: `led[i]`=1 iff i == L-1. L=0 gives all off.
- `led` is registered from the next-state `s` and mode, so it changes on the same edge as `s`.
- `wrap` is registered high for one cycle after the edge where `s` goes TOTAL→0.
- `sq_out` is registered: 1 while `cnt` ≥ DIV/2 (integer), else 0.
- `clr`=1, sampled on an edge: `cnt`←0, `s`←0, `led`←0, `wrap`←0.
  - `clr` has priority over `en` and `tick`.
  - A clear never produces `wrap`.
- `en`=0: `cnt`, `s`, `led` and `sq_out` hold; `tick`=0.
- `mode` change takes effect on the next edge even with `en`=0 (led re-decoded from held `s`).
- Priority order: `rst` > `clr` > `en`/`tick`.
- No wrap-around overflow: `s` never exceeds TOTAL, and `cnt` never exceeds DIV-1.

## Timing
- Reset values: `cnt`=0, `s`=0, `led`=0, `tick`=0, `wrap`=0, `sq_out`=0, `step`=0.
- `rst` asserted mid-operation clears all registers immediately, without waiting for a clock edge.
- First edge after `rst` deassert with `en`=1: `cnt`=1.
- `tick` is high during the DIV-th cycle after reset release (`cnt`=DIV-1).
- Latency from `tick` to `step`/`led`: updated on the edge ending the `tick` cycle.
- Tick period is exactly DIV cycles while `en`=1. Pauses extend it by the number of `en`=0 cycles.
- Full sweep is (TOTAL+1) ticks; `wrap` follows the (TOTAL+1)-th tick by one edge.
- `sq_out` is high for DIV − DIV/2 cycles per period and lags `cnt` by one cycle.

## Configuration
- Macro: `LED_BARGRAPH_DOT_MODE_EN`.
- Defined: `mode` selects bar (0) or dot (1) decode as above.
- Undefined: the dot decoder is not compiled, `mode` is ignored, and behaviour is bar only. The port remains, so instantiations are unchanged.

## Test plan
All scenarios use DIV=4, N_LED=3, STEPS_PER_LED=2 (TOTAL=6).
- Reset: `rst`=1 for 3 cycles → all outputs 0. Assert `rst` mid-sweep at `s`=4 → `step`=0 and `led`=000 before the next edge.
- Prescaler: `en`=1 → `tick` high one cycle in every 4, first on cycle 4. `sq_out` pattern over a period is 0,0,1,1, delayed one cycle.
- Bar sweep, `mode`=0:
  - After 2 ticks: `led`=001. After 4: `led`=011. After 6: `led`=111, `step`=6.
  - 7th tick: `step`=0, `led`=000, and `wrap` high for exactly one cycle.
- Dot mode with macro, `mode`=1: after 2 ticks `led`=001, after 4 `led`=010, after 6 `led`=100.
  - Without the macro, the same stimulus gives 001/011/111.
- Pause: `en`=0 for 10 cycles at `step`=3 → `step`, `led` and `sq_out` unchanged, with no `tick`. Resume → the next `tick` arrives after the remaining prescaler cycles.
- Clear: `clr`=1 coincident with `tick` at `step`=6 → `step`=0, `led`=000, `wrap` stays 0, and `cnt` restarts from 0.
